mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the data-side memory map (RAM and UART slaves) between the CPU MEM stage (master 0) and a second bus master such as a DMA or debug engine (master 1). The arbiter grants at most one single-beat transaction per cycle and applies a bounded-burst fairness rule. It returns registered read data to the winning master and raises a stall toward the pipeline whenever the MEM stage is refused. It sits between the EX/MEM pipeline register and the memory-map address/data inputs.

---
 rtl/mem_bus_arbiter_if.sv | 56 +++++
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// data-side memory map. The arbiter connects through the slave modport.
// The master modport is the view of the environment that drives the
// requests and the memory-map read data.
interface mem_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Master 0 (CPU MEM stage)
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wd;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rd;

    // Master 1 (DMA / debug engine)
    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wd;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rd;

    // Memory-map side
    logic                  s_we;
    logic                  s_re;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wd;
    logic [DATA_WIDTH-1:0] s_rd;

    // Pipeline hold request
    logic                  cpu_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        input  s_rd,
        output m0_gnt, m0_rvalid, m0_rd,
        output m1_gnt, m1_rvalid, m1_rd,
        output s_we, s_re, s_addr, s_wd,
        output cpu_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        output m1_req, m1_we, m1_addr, m1_wd,
        output s_rd,
        input  m0_gnt, m0_rvalid, m0_rd,
        input  m1_gnt, m1_rvalid, m1_rd,
        input  s_we, s_re, s_addr, s_wd,
        input  cpu_stall
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master single-beat arbiter in front of the data memory map.
// The grant is combinational from the requests and the registered owner/burst
// state. Under contention the current owner keeps the bus for at most
// MAX_BURST consecutive grants before the other master is served. Read data is
// captured at the end of the grant cycle and returned with a one-cycle rvalid.
module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
    localparam logic [BW-1:0] ONE_B = BW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } st_t;

    st_t            st_q, st_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic [BW-1:0]  burst_inc;

    // Per-master views so the read-return path can be generated once
    logic [1:0]                  req;
    logic [1:0]                  we;
    logic [1:0]                  gnt;
    logic [ADDR_WIDTH-1:0]       addr [2];
    logic [DATA_WIDTH-1:0]       wd   [2];
    logic [1:0]                  rvalid_q;
    logic [DATA_WIDTH-1:0]       rd_q [2];

    assign req     = {bus.m1_req, bus.m0_req};
    assign we      = {bus.m1_we,  bus.m0_we};
    assign addr[0] = bus.m0_addr;
    assign addr[1] = bus.m1_addr;
    assign wd[0]   = bus.m0_wd;
    assign wd[1]   = bus.m1_wd;

    assign burst_inc = (burst_q == MAX_B) ? MAX_B : burst_q + ONE_B;

    // Grant decision: lone requester wins; on contention the owner keeps the
    // bus until its burst count saturates, IDLE favours the CPU. Reset blocks
    // every grant so nothing reaches the memory map while rst_n is low.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b01) begin
                gnt = 2'b01;
            end else if (req == 2'b10) begin
                gnt = 2'b10;
            end else if (req == 2'b11) begin
                case (st_q)
                    OWN0:    gnt = (burst_q < MAX_B) ? 2'b01 : 2'b10;
                    OWN1:    gnt = (burst_q < MAX_B) ? 2'b10 : 2'b01;
                    default: gnt = 2'b01;
                endcase
            end
        end
    end

    // Next owner and burst count; an idle cycle forgets the previous owner
    always_comb begin
        st_d    = IDLE;
        burst_d = '0;
        if (gnt[0]) begin
            st_d    = OWN0;
            burst_d = (st_q == OWN0) ? burst_inc : ONE_B;
        end else if (gnt[1]) begin
            st_d    = OWN1;
            burst_d = (st_q == OWN1) ? burst_inc : ONE_B;
        end
    end

    // Owner/burst state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            burst_q <= '0;
        end else begin
            st_q    <= st_d;
            burst_q <= burst_d;
        end
    end

    // Memory-map mux: follows the winner, all zero when nobody is granted
    always_comb begin
        bus.s_addr = '0;
        bus.s_wd   = '0;
        bus.s_we   = 1'b0;
        bus.s_re   = 1'b0;
        if (gnt[0]) begin
            bus.s_addr = addr[0];
            bus.s_wd   = wd[0];
            bus.s_we   = we[0];
            bus.s_re   = ~we[0];
        end else if (gnt[1]) begin
            bus.s_addr = addr[1];
            bus.s_wd   = wd[1];
            bus.s_we   = we[1];
            bus.s_re   = ~we[1];
        end
    end

    // The MEM stage must hold whenever it asks and is refused
    assign bus.cpu_stall = rst_n & req[0] & ~gnt[0];

    // Read return: capture combinational s_rd at the end of a granted read and
    // flag it for exactly one cycle; rd holds until that master's next read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_ret
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q[gi] <= 1'b0;
                rd_q[gi]     <= '0;
            end else begin
                rvalid_q[gi] <= gnt[gi] & ~we[gi];
                if (gnt[gi] && !we[gi]) begin
                    rd_q[gi] <= bus.s_rd;
                end
            end
        end
    end

    assign bus.m0_gnt    = gnt[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rd     = rd_q[0];
    assign bus.m1_rd     = rd_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random checks of mem_bus_arbiter against a history-based model:
// the model keeps the list of past winners and decides fairness by counting
// the length of the latest run of same-master grants.
module tb_mem_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_bus_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: past winners (-1 = idle cycle) and pending read returns
    int          hist[$];
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];

    // Observations from the most recent cycle for directed checks
    int          o_win;
    logic        o_stall;
    logic        o_we;
    logic        o_re;
    logic        o_rv0;
    logic [31:0] o_rd0;
    logic [31:0] o_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_win(input bit r0, input bit r1);
        int last;
        int run;
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (hist.size() == 0) return 0;
        last = hist[hist.size()-1];
        if (last < 0) return 0;
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != last) break;
            run++;
        end
        return (run < MB) ? last : 1 - last;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] srd);
        bus.m0_req  = r0;
        bus.m0_we   = w0;
        bus.m0_addr = a0;
        bus.m0_wd   = d0;
        bus.m1_req  = r1;
        bus.m1_we   = w1;
        bus.m1_addr = a1;
        bus.m1_wd   = d1;
        bus.s_rd    = srd;
    endtask

    // One bus cycle: drive at negedge, check everything just after, let the
    // posedge happen and advance the model.
    task automatic cycle(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] srd, input string tag);
        int          win;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        @(negedge clk);
        drive(r0, w0, a0, d0, r1, w1, a1, d1, srd);
        #1;
        win    = model_win(r0, r1);
        e_we   = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
        e_addr = (win == 0) ? a0 : (win == 1) ? a1 : 32'h0;
        e_wd   = (win == 0) ? d0 : (win == 1) ? d1 : 32'h0;
        chk({tag, ".m0_gnt"},    32'(bus.m0_gnt),    32'(win == 0));
        chk({tag, ".m1_gnt"},    32'(bus.m1_gnt),    32'(win == 1));
        chk({tag, ".s_we"},      32'(bus.s_we),      32'(e_we));
        chk({tag, ".s_re"},      32'(bus.s_re),      32'(win >= 0 && !e_we));
        chk({tag, ".s_addr"},    bus.s_addr,         e_addr);
        chk({tag, ".s_wd"},      bus.s_wd,           e_wd);
        chk({tag, ".cpu_stall"}, 32'(bus.cpu_stall), 32'(r0 && win != 0));
        chk({tag, ".m0_rvalid"}, 32'(bus.m0_rvalid), 32'(exp_rv[0]));
        chk({tag, ".m1_rvalid"}, 32'(bus.m1_rvalid), 32'(exp_rv[1]));
        chk({tag, ".m0_rd"},     bus.m0_rd,          exp_rd[0]);
        chk({tag, ".m1_rd"},     bus.m1_rd,          exp_rd[1]);
        o_win   = bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : -1);
        o_stall = bus.cpu_stall;
        o_we    = bus.s_we;
        o_re    = bus.s_re;
        o_wd    = bus.s_wd;
        o_rv0   = bus.m0_rvalid;
        o_rd0   = bus.m0_rd;
        @(posedge clk);
        hist.push_back(win);
        if (hist.size() > MB + 2) void'(hist.pop_front());
        exp_rv[0] = (win == 0) && !w0;
        exp_rv[1] = (win == 1) && !w1;
        if (exp_rv[0]) exp_rd[0] = srd;
        if (exp_rv[1]) exp_rd[1] = srd;
        $display("cycle %-10s win=%0d stall=%0b s_we=%0b s_re=%0b addr=%h", tag, o_win, o_stall, o_we, o_re, e_addr);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, tag);
    endtask

    initial begin
        // Reset with both masters requesting: nothing may be granted
        rst_n = 1'b0;
        model_reset();
        drive(1, 0, 32'h1000_0000, 32'h0, 1, 0, 32'h2000_0000, 32'h0, 32'h5555_5555);
        #2;
        chk("rst.m0_gnt",    32'(bus.m0_gnt),    32'h0);
        chk("rst.m1_gnt",    32'(bus.m1_gnt),    32'h0);
        chk("rst.s_re",      32'(bus.s_re),      32'h0);
        chk("rst.s_addr",    bus.s_addr,         32'h0);
        chk("rst.cpu_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rst.m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
        chk("rst.m0_rd",     bus.m0_rd,          32'h0);
        chk("rst.m1_rd",     bus.m1_rd,          32'h0);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Lone m0 read
        cycle(1, 0, 32'h1001_0004, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, "lone_rd");
        chk("lone_rd.win", 32'(o_win), 32'h0);
        chk("lone_rd.re",  32'(o_re),  32'h1);
        idle("lone_ret");
        chk("lone_ret.rvalid", 32'(o_rv0), 32'h1);
        chk("lone_ret.rd",     o_rd0,      32'hDEAD_BEEF);

        // Continuous contention: m0 x4, m1 x4, m0 x4
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 32'h1001_0000 + 32'(i*4), 32'h0, 1, 0, 32'h2000_0000 + 32'(i*4), 32'h0,
                  $urandom, "contend");
            chk("contend.seq",   32'(o_win),   32'((i >= 4 && i < 8) ? 1 : 0));
            chk("contend.stall", 32'(o_stall), 32'(i >= 4 && i < 8));
        end

        // m1 alone for 6 cycles, then m0 joins and wins immediately
        idle("gap");
        for (int i = 0; i < 6; i++)
            cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h3000_0000 + 32'(i), $urandom, 32'h0, "m1_alone");
        cycle(1, 0, 32'h1001_0010, 32'h0, 1, 1, 32'h3000_0010, 32'h77, 32'h0BAD_F00D, "join");
        chk("join.win", 32'(o_win), 32'h0);

        // m0 write then read of the same address
        idle("gap");
        cycle(1, 1, 32'h1001_0008, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 32'h0, "wr");
        chk("wr.s_we", 32'(o_we), 32'h1);
        chk("wr.s_wd", o_wd,      32'h1234_5678);
        cycle(1, 0, 32'h1001_0008, 32'h0, 0, 0, 32'h0, 32'h0, 32'h1234_5678, "rd");
        chk("rd.s_re",   32'(o_re),  32'h1);
        chk("rd.rvalid", 32'(o_rv0), 32'h0);
        idle("rd_ret");
        chk("rd_ret.rvalid", 32'(o_rv0), 32'h1);
        chk("rd_ret.rd",     o_rd0,      32'h1234_5678);

        // Asynchronous reset during an m1 read grant, with an m0 read pending
        cycle(1, 0, 32'h1001_0020, 32'h0, 0, 0, 32'h0, 32'h0, 32'hA5A5_A5A5, "pre_rst");
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h2000_0040, 32'h0, 32'h1111_2222);
        #1;
        chk("mid.m1_gnt",    32'(bus.m1_gnt),    32'h1);
        chk("mid.m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.m1_gnt",    32'(bus.m1_gnt),    32'h0);
        chk("arst.s_re",      32'(bus.s_re),      32'h0);
        chk("arst.s_addr",    bus.s_addr,         32'h0);
        chk("arst.m0_rvalid", 32'(bus.m0_rvalid), 32'h0);
        chk("arst.m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
        chk("arst.m0_rd",     bus.m0_rd,          32'h0);
        $display("async reset asserted during m1 read grant");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1, 0, 32'h1001_0030, 32'h0, 1, 0, 32'h2000_0030, 32'h0, 32'h3333_4444, "post_rst");
        chk("post_rst.win", 32'(o_win), 32'h0);

        // Idle gap after a short m0 burst restarts the count
        idle("gap");
        cycle(1, 0, 32'h1001_0040, 32'h0, 0, 0, 32'h0, 32'h0, 32'h1, "burst2");
        cycle(1, 0, 32'h1001_0044, 32'h0, 0, 0, 32'h0, 32'h0, 32'h2, "burst2");
        idle("gap");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 32'h1001_0050, 32'h0, 1, 0, 32'h2000_0050, 32'h0, $urandom, "restart");
            chk("restart.seq", 32'(o_win), 32'((i < 4) ? 0 : 1));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
